// File: rtl/aes_share_pkg.sv
// Shared types and constants for the two-share masked SubBytes sequencer.
// Holds the sequencer FSM encoding, the LFSR polynomial/seed and the state size.
package aes_share_pkg;

  localparam int          NBYTES         = 16;
  localparam logic [31:0] LFSR_POLY      = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED_DFLT = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/aes_share_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) feeding S-box randomness; a zero seed is
// replaced by the nonzero default so the register can never lock up.
module aes_share_lfsr32
  import aes_share_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [27:0] rnd
);

  logic [31:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED_DFLT;
    end else if (load) begin
      state_q <= (seed == '0) ? LFSR_SEED_DFLT : seed;
    end else if (en) begin
      state_q <= {state_q[30:0], 1'b0} ^ (state_q[31] ? LFSR_POLY : '0);
    end
  end

  assign rnd = state_q[27:0];

endmodule

// File: rtl/aes_subbytes_share_seq.sv
// Streams a two-share AES state byte-by-byte through an external pipelined masked
// S-box and reassembles the result; result valid NBYTES+SBOX_LAT edges after accept.
module aes_subbytes_share_seq
  import aes_share_pkg::*;
#(
  parameter int SBOX_LAT = 2,
  parameter int NBYTES   = aes_share_pkg::NBYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ed,
  input  logic [8*NBYTES-1:0] in_share0,
  input  logic [8*NBYTES-1:0] in_share1,
  input  logic [31:0]         in_seed,
  output logic [7:0]          sb_a,
  output logic [7:0]          sb_b,
  output logic                sb_ed,
  output logic [27:0]         sb_random,
  input  logic [7:0]          sb_s0,
  input  logic [7:0]          sb_s1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_share0,
  output logic [8*NBYTES-1:0] out_share1
);

  localparam int               CNT_W = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES - 1);

  seq_state_e state_q, state_d;

  logic [NBYTES-1:0][7:0] s0_q, s1_q, out0_q, out1_q;
  logic                   ed_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SBOX_LAT-1:0]    pipe_vld;
  logic [CNT_W-1:0]       pipe_idx [SBOX_LAT];
  logic [27:0]            lfsr_rnd;

  logic accept, feed, cap;
  logic [CNT_W-1:0] cap_idx;

  assign accept  = (state_q == IDLE) && in_valid;
  assign feed    = (state_q == FEED);
  assign cap     = pipe_vld[SBOX_LAT-1];
  assign cap_idx = pipe_idx[SBOX_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                 state_d = FEED;
      FEED:    if (cnt_q == LAST)            state_d = DRAIN;
      DRAIN:   if (cap && (cap_idx == LAST)) state_d = DONE;
      DONE:    if (out_ready)                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Share buses are forced to zero outside FEED so no share value lingers on them.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sb_a      = '0;
    sb_b      = '0;
    sb_random = '0;
    if (feed) begin
      sb_a      = s0_q[cnt_q];
      sb_b      = s1_q[cnt_q];
      sb_random = lfsr_rnd;
    end
  end

  assign sb_ed      = ed_q;
  assign out_share0 = out0_q;
  assign out_share1 = out1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      ed_q  <= 1'b1;
      cnt_q <= '0;
    end else if (accept) begin
      s0_q  <= in_share0;
      s1_q  <= in_share1;
      ed_q  <= in_ed;
      cnt_q <= '0;
    end else if (feed) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Issue tracker mirrors the S-box latency so each returning byte lands in its own slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < SBOX_LAT; k++) pipe_idx[k] <= '0;
    end else begin
      pipe_vld[0] <= feed;
      pipe_idx[0] <= cnt_q;
      for (int k = 1; k < SBOX_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
      out1_q <= '0;
    end else if (cap) begin
      out0_q[cap_idx] <= sb_s0;
      out1_q[cap_idx] <= sb_s1;
    end
  end

  aes_share_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (feed),
    .seed  (in_seed),
    .rnd   (lfsr_rnd)
  );

endmodule

// File: tb/tb_aes_subbytes_share_seq.sv
// Bench: sequencer plus a behavioural two-stage masked S-box, scoreboarded against
// a GF(2^8)-derived reference S-box.
module tb_aes_subbytes_share_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ed = 1'b1, out_ready = 1'b1;
  logic [127:0] in_share0 = '0, in_share1 = '0;
  logic [31:0]  in_seed = '0;
  logic         in_ready, out_valid, sb_ed;
  logic [7:0]   sb_a, sb_b, sb_s0, sb_s1;
  logic [27:0]  sb_random;
  logic [127:0] out_share0, out_share1;

  aes_subbytes_share_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ed(in_ed),
    .in_share0(in_share0), .in_share1(in_share1), .in_seed(in_seed),
    .sb_a(sb_a), .sb_b(sb_b), .sb_ed(sb_ed), .sb_random(sb_random),
    .sb_s0(sb_s0), .sb_s1(sb_s1), .out_valid(out_valid), .out_ready(out_ready),
    .out_share0(out_share0), .out_share1(out_share1)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] v, input logic ed);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ed ? sbox_t[v[8*i +: 8]] : inv_t[v[8*i +: 8]];
    return r;
  endfunction

  // Behavioural masked S-box: two register stages, mask taken from the randomness bus.
  logic [7:0]  p_a, p_b, p_m, s0_r, s1_r;
  logic        p_ed;
  always @(posedge clk) begin
    p_a  <= sb_a;
    p_b  <= sb_b;
    p_ed <= sb_ed;
    p_m  <= sb_random[7:0] ^ sb_random[27:20];
    s0_r <= (p_ed ? sbox_t[p_a ^ p_b] : inv_t[p_a ^ p_b]) ^ p_m;
    s1_r <= p_m;
  end
  assign sb_s0 = s0_r;
  assign sb_s1 = s1_r;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, cur_e0 = -1000, acc_cnt = 0, sends = 0;
  logic [127:0] cur_v;
  logic         cur_ed;
  logic [31:0]  cur_seed;
  logic         prev_ov = 1'b0;
  logic         bp_en = 1'b0;
  logic [127:0] exp_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Input-side observer: records the accept edge and what was accepted.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) cur_e0 = -1000;
    else if (in_valid && in_ready) begin
      cur_e0   = cyc;
      cur_v    = in_share0 ^ in_share1;
      cur_ed   = in_ed;
      cur_seed = (in_seed == 32'h0) ? 32'h1 : in_seed;
      acc_cnt++;
    end
  end

  // Output/bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_e0 = -1000;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_sb_bus", {sb_a, sb_b, sb_random}, '0);
      chk("rst_sb_ed", 128'(sb_ed), 128'(1'b1));
    end else begin
      if (cyc >= cur_e0 && cyc < cur_e0 + 16) begin
        chk("feed_byte", 128'(sb_a ^ sb_b), 128'(cur_v[8*(cyc-cur_e0) +: 8]));
        chk("feed_ed", 128'(sb_ed), 128'(cur_ed));
        if (cyc == cur_e0) chk("first_random", 128'(sb_random), 128'(cur_seed[27:0]));
      end else begin
        chk("idle_bus_zero", {sb_a, sb_b, sb_random}, '0);
      end
      if (out_valid && !prev_ov) chk("latency", 128'(cyc - cur_e0), 128'(18));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 128'(1), 128'(0));
        else chk("result", out_share0 ^ out_share1, exp_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) if (bp_en) begin
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [127:0] s0, input logic [127:0] s1, input logic ed,
                      input logic [31:0] seed);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 128'(1), 128'(0));
      return;
    end
    in_share0 = s0; in_share1 = s1; in_ed = ed; in_seed = seed; in_valid = 1'b1;
    exp_q.push_back(ref_sub(s0 ^ s1, ed));
    sends++;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_share0 = {$urandom, $urandom, $urandom, $urandom};
    in_share1 = {$urandom, $urandom, $urandom, $urandom};
    in_ed     = $urandom_range(0, 1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] v, m, s0, s1, want;
    logic [7:0]   b, inv;
    int t;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_t[x] = b;
    end
    for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);
    chk("ref_s_00", 128'(sbox_t[8'h00]), 128'(8'h63));
    chk("ref_s_53", 128'(sbox_t[8'h53]), 128'(8'hED));
    chk("ref_s_01", 128'(sbox_t[8'h01]), 128'(8'h7C));

    repeat (3) @(posedge clk);
    chk("rst_out_share0", out_share0, '0);
    chk("rst_out_share1", out_share1, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero state, encrypt.
    send('0, '0, 1'b1, 32'hDEADBEEF);

    // Two known bytes, once with a real seed and once with seed 0.
    s0 = rnd128(); s1 = s0;
    s0[7:0] = 8'h50; s1[7:0] = 8'h03; s0[15:8] = 8'hA5; s1[15:8] = 8'hA4;
    want = {{14{8'h63}}, 8'h7C, 8'hED};
    chk("ref_two_bytes", ref_sub(s0 ^ s1, 1'b1), want);
    send(s0, s1, 1'b1, $urandom);
    send(s0, s1, 1'b1, 32'h0);

    // Decrypt 0x63 -> 0x00 and 0xED -> 0x53 under random masks.
    m = rnd128(); send({16{8'h63}} ^ m, m, 1'b0, $urandom);
    m = rnd128(); send({16{8'hED}} ^ m, m, 1'b0, $urandom);
    chk("ref_inv_ed", ref_sub({16{8'hED}}, 1'b0), {16{8'h53}});

    // Hold the result in DONE while poking the input side.
    m = rnd128(); v = rnd128();
    send(v ^ m, m, 1'b1, $urandom);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("hold_reach_done", 128'(out_valid), 128'(1'b1));
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; in_share0 = rnd128();
      @(posedge clk); #1;
      chk("hold_valid", 128'(out_valid), 128'(1'b1));
      chk("hold_in_ready", 128'(in_ready), 128'(1'b0));
      chk("hold_data", out_share0 ^ out_share1, ref_sub(v, 1'b1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 128'(out_valid), 128'(1'b0));
    chk("release_in_ready", 128'(in_ready), 128'(1'b1));
    chk("accept_count", 128'(acc_cnt), 128'(sends));

    // Abort mid-FEED, then a fresh state must come out clean.
    send(rnd128(), rnd128(), 1'b1, $urandom);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("post_reset_idle", {out_valid, in_ready}, {1'b0, 1'b1});
    m = rnd128(); send(rnd128() ^ m, m, 1'b0, $urandom);

    // Random regression with downstream backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(rnd128(), rnd128(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
    bp_en = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    chk("drain_outstanding", 128'(exp_q.size()), 128'(0));
    chk("final_accepts", 128'(acc_cnt), 128'(sends));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_share_seq.md
Name: aes_subbytes_share_seq

Overview:
- Sequences a full 128-bit two-share masked AES state through one shared two-share S-box datapath (AES_SBOX_PIPELINED), one byte per clock.
- Sits between the round-state register and that datapath.
- Drives the S-box's share inputs, direction select and 28-bit randomness from an internal LFSR.
- Collects the pipelined output shares back into a 128-bit two-share state, handed to ShiftRows/InvShiftRows with a valid/ready handshake.

Parameters:
- SBOX_LAT, 2, clock edges from an S-box input being applied to its shares appearing on s_out0/s_out1.
- NBYTES, 16, bytes per state; the byte counter is sized clog2(NBYTES).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state shares and seed valid
- in_ready  out  1  block can accept a state
- in_ed  in  1  1 = encrypt (SubBytes), 0 = decrypt (InvSubBytes)
- in_share0  in  128  share 0 of state; byte i = bits [8i+7:8i]
- in_share1  in  128  share 1 of state
- in_seed  in  32  LFSR seed, loaded on accept
- sb_a  out  8  to S-box a (share 0 of current byte)
- sb_b  out  8  to S-box b (share 1 of current byte)
- sb_ed  out  1  to S-box E_D
- sb_random  out  28  to S-box random
- sb_s0  in  8  from S-box s_out0
- sb_s1  in  8  from S-box s_out1
- out_valid  out  1  result shares valid
- out_ready  in  1  downstream accepts result
- out_share0  out  128  result share 0, byte order as input
- out_share1  out  128  result share 1

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1, out_valid=0; out_share0/1=0; sb_a=sb_b=0; sb_ed=1; LFSR=32'h1; byte counter, issue-tracking pipe and capture index cleared.
  - Reset mid-operation aborts silently; no partial result is ever presented.
- FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge (accept edge E0): register both shares and in_ed.
  - Load LFSR with in_seed (seed 0 is replaced by 32'h1).
  - Counter=0; go to FEED.
- FEED (NBYTES cycles):
  - sb_a/sb_b = registered byte[cnt] of share0/share1.
  - sb_ed = latched ed.
  - sb_random = LFSR[27:0].
  - LFSR is a 32-bit Galois register, taps x^32+x^22+x^2+x+1, advancing once per FEED cycle.
  - Counter increments each edge; after byte NBYTES-1 go to DRAIN.
- Issue tracking: an SBOX_LAT-deep valid shift pipe with byte index.
  - A bit enters at each edge ending a FEED cycle.
  - When a bit exits, sb_s0/sb_s1 are written into byte[index] of out_share0/out_share1.
  - Byte i is captured at edge E0+1+i+SBOX_LAT.
- DRAIN: sb_a=sb_b=0, sb_random=0; LFSR holds. Leave DRAIN at the edge capturing the last byte.
- Latency: out_valid rises at edge E0+NBYTES+SBOX_LAT (18 for defaults).
- DONE:
  - out_valid=1; outputs stable while out_ready=0.
  - On out_valid&&out_ready edge: out_valid=0, go to IDLE; in_ready=1 from that edge.
  - No bypass: the next accept happens no earlier than the following edge.
- in_ready=0 in FEED/DRAIN/DONE; in_valid is ignored there and in_share*/in_ed changes have no effect.
- Masking rules:
  - Shares are never XOR-combined inside this block.
  - sb_a/sb_b are 0 outside FEED, so no share lingers on the bus.
  - sb_ed only changes in IDLE.
- Correctness, per byte: out_share0[i]^out_share1[i] = S(in_share0[i]^in_share1[i]) for ed=1, and S^-1(...) for ed=0, for any seed.

Decomposition:
- Shared package aes_share_pkg holds:
  - FSM state enum (IDLE, FEED, DRAIN, DONE)
  - LFSR polynomial constant 32'h0040_0007
  - nonzero seed default 32'h1
  - NBYTES
- Natural sub-module: aes_share_lfsr32 (load, enable, seed, 32-bit state; zero-seed substitution inside).
- The S-box datapath stays outside and is connected by the integrating top.
- The bench wraps aes_subbytes_share_seq together with AES_SBOX_PIPELINED.

Test Plan:
- ed=1, share0=share1=0, seed 0xDEADBEEF -> out_valid at edge E0+18; every byte of out_share0^out_share1 = 0x63.
- ed=1, byte0 shares 0x50/0x03 (value 0x53), byte1 shares 0xA5/0xA4 (value 0x01), other bytes value 0x00 -> combined byte0=0xED, byte1=0x7C, rest 0x63; repeat with seed 0 and check identical combined result with LFSR running from 1.
- ed=0, all bytes value 0x63 split by random mask -> combined 0x00 per byte; 0xED -> 0x53.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_share0 -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
- Assert rst_n low at edge E0+9 (mid-FEED), release, then issue a new state -> out_valid=0 during and after reset; the new result is correct and uncontaminated by the aborted state.
- Random-share regression: 1000 states with random values, masks, seeds and ed, checked against a reference S-box; sb_a=sb_b=0 whenever the FSM is not in FEED.
